// File: rtl/ex_redirect_ctrl.sv
// ex_redirect_ctrl
//
// Control block at the EX end of the ID/EX pipeline register. It looks at the
// decoded control flags that ID/EX presents to EX and produces three things:
//   * the PC redirect select for jumps, returns and taken branches,
//   * a multi-cycle flush that removes wrong-path instructions from IF/ID and
//     ID/EX after a redirect,
//   * a stall and req/ack handshake that sequences board-peripheral
//     operations (get row, send row, move/write shape), with a timeout.
//
// Optional feature: define EX_REDIRECT_PERF_EN to build the two 16-bit
// saturating performance counters (redirect cycles, stall cycles). When it is
// not defined, redirect_cnt and stall_cnt are tied to zero and no counter
// flops exist.
//
// Peripheral handshake (valid/ready style): periph_req is a level that stays
// high from the first REQ cycle until the cycle periph_ack is seen (or the
// timeout fires). periph_op is stable for the whole time periph_req is high.
// periph_ack is a single-cycle pulse; it is only honoured while periph_req is
// high and is ignored in every other state.

module ex_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 2,   // cycles flush stays high, 1..3
  parameter int TIMEOUT      = 255, // REQ cycles before the op is abandoned
  parameter int TW           = 8    // timeout counter width, 2^TW > TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,                   // asynchronous, active low
  input  logic        isJ_ex,
  input  logic        isJAL_ex,
  input  logic        isReturn_ex,
  input  logic        isBR_ex,
  input  logic        br_taken,
  input  logic        ifGetRow_ex,
  input  logic        ifSendRow_ex,
  input  logic        isMoveOrWriteShape_ex,
  input  logic        periph_ack,
  output logic        redirect,
  output logic        flush,
  output logic        stall,
  output logic        periph_req,
  output logic [1:0]  periph_op,
  output logic        periph_timeout,
  output logic [15:0] redirect_cnt,
  output logic [15:0] stall_cnt
);

  // FSM encoding
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  // Peripheral operation codes
  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_GET   = 2'b01;
  localparam logic [1:0] OP_SEND  = 2'b10;
  localparam logic [1:0] OP_SHAPE = 2'b11;

  // Flush counter reload value and the last REQ count before giving up.
  // REQ lasts at most TIMEOUT cycles: the counter holds 0 in the first REQ
  // cycle and TIMEOUT-1 in the last one.
  localparam logic [1:0]    FLUSH_LOAD   = 2'(FLUSH_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  // State registers
  logic [1:0]    flush_cnt_q, flush_cnt_d;
  logic [1:0]    state_q,     state_d;
  logic [1:0]    op_q,        op_d;
  logic [TW-1:0] tcnt_q,      tcnt_d;
  logic          timeout_q,   timeout_d;

  // Decoded EX-stage intent
  logic          jump_taken;
  logic          op_flag;
  logic          pop;
  logic [1:0]    op_sel;

  // Decode control-flow and peripheral intent from the ID/EX flags. Both are
  // masked by flush, because the instruction in EX is wrong-path then, and by
  // reset so nothing leaks out while reset is held.
  always_comb begin
    jump_taken = isJ_ex | isJAL_ex | isReturn_ex | (isBR_ex & br_taken);
    op_flag    = ifGetRow_ex | ifSendRow_ex | isMoveOrWriteShape_ex;
    flush      = (flush_cnt_q != 2'd0);
    redirect   = rst & jump_taken & ~flush;
    pop        = rst & op_flag & ~flush;
  end

  // Fixed priority when several op flags are set: getRow > sendRow > shape.
  always_comb begin
    op_sel = OP_NONE;
    if (ifGetRow_ex) begin
      op_sel = OP_GET;
    end else if (ifSendRow_ex) begin
      op_sel = OP_SEND;
    end else if (isMoveOrWriteShape_ex) begin
      op_sel = OP_SHAPE;
    end
  end

  // Flush counter: a redirect loads it, otherwise it counts down to zero.
  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (redirect) begin
      flush_cnt_d = FLUSH_LOAD;
    end else if (flush_cnt_q != 2'd0) begin
      flush_cnt_d = flush_cnt_q - 2'd1;
    end
  end

  // Peripheral sequencer: next state, held op, timeout count and outputs.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    tcnt_d     = tcnt_q;
    timeout_d  = timeout_q;
    stall      = 1'b0;
    periph_req = 1'b0;
    periph_op  = OP_NONE;
    case (state_q)
      S_IDLE: begin
        // The op is stalled in EX from the very cycle it is seen.
        if (pop) begin
          stall   = 1'b1;
          op_d    = op_sel;
          tcnt_d  = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        stall      = 1'b1;
        periph_req = 1'b1;
        periph_op  = op_q;
        tcnt_d     = tcnt_q + TW'(1);
        // An ack in the last allowed cycle still counts as success.
        if (periph_ack) begin
          state_d = S_RELEASE;
        end else if (tcnt_q == TIMEOUT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // Stall drops so the held instruction leaves EX; its flags may still
        // be visible this cycle, so IDLE is entered without looking at pop.
        op_d    = OP_NONE;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        op_d    = OP_NONE;
      end
    endcase
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_cnt_q <= 2'd0;
      state_q     <= S_IDLE;
      op_q        <= OP_NONE;
      tcnt_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      state_q     <= state_d;
      op_q        <= op_d;
      tcnt_q      <= tcnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign periph_timeout = timeout_q;

`ifdef EX_REDIRECT_PERF_EN
  logic [15:0] redirect_cnt_q;
  logic [15:0] stall_cnt_q;

  // Saturating counts of redirect cycles and stall cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_cnt_q <= 16'h0000;
      stall_cnt_q    <= 16'h0000;
    end else begin
      if (redirect && (redirect_cnt_q != 16'hFFFF)) begin
        redirect_cnt_q <= redirect_cnt_q + 16'h0001;
      end
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'h0001;
      end
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`else
  assign redirect_cnt = 16'h0000;
  assign stall_cnt    = 16'h0000;
`endif

endmodule
